// File: rtl/letter_div_arb_pkg.sv
// Shared types and defaults for the letter_div round-robin arbiter.
package letter_div_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_FREE = 2'd3
  } arb_state_e;

  localparam int DATA_SIZE_DEF = 32;
  localparam int MIN_GAP_DEF   = 8;
  localparam int WORD_CNT_W    = 16;

endpackage

// File: rtl/letter_div_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; searches upward from rr_ptr_i+1 with wrap.
module rr_pick
  import letter_div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_IDW = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [REQ_IDW-1:0] rr_ptr_i,
  output logic               valid_o,
  output logic [REQ_IDW-1:0] winner_o
);

  logic [REQ_IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set request is the last write.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = REQ_IDW'((int'(rr_ptr_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/letter_div_arb.sv
// letter_div_arb: round-robin sequencer sharing one letter_div across NUM_REQ ports.
// Optional watchdog on the handshake wait states enabled by `LETTER_ARB_WDOG_EN.
`default_nettype none
module letter_div_arb
  import letter_div_arb_pkg::*;
#(
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int NUM_REQ     = 4,
  parameter int REQ_IDW     = 2,
`ifdef LETTER_ARB_WDOG_EN
  parameter int WDOG_CYCLES = 64,
`endif
  parameter int MIN_GAP     = MIN_GAP_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           write_free,
  output logic [DATA_SIZE-1:0]           data_out,
  output logic                           data_wr,
  output logic [REQ_IDW-1:0]             grant_id,
  output logic                           busy,
`ifdef LETTER_ARB_WDOG_EN
  output logic                           wdog_err,
`endif
  output logic [WORD_CNT_W-1:0]          word_cnt
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);

  arb_state_e              state_q, state_d;
  logic [REQ_IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic                    data_wr_q, data_wr_d;
  logic [REQ_IDW-1:0]      grant_q, grant_d;
  logic                    busy_q;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic                    pick_valid;
  logic [REQ_IDW-1:0]      pick_winner;
  logic [DATA_SIZE-1:0]    sel_data;
  logic [NUM_REQ-1:0]      sel_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_IDW (REQ_IDW)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  always_comb begin
    sel_data   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner == REQ_IDW'(i)) begin
        sel_data      = req_data[i*DATA_SIZE +: DATA_SIZE];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef LETTER_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gap_d      = (gap_q != '0) ? gap_q - 1'b1 : '0;
    ack_d      = '0;
    data_wr_d  = 1'b0;
    data_out_d = data_out_q;
    grant_d    = grant_q;
    word_cnt_d = word_cnt_q;
`ifdef LETTER_ARB_WDOG_EN
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && write_free && (gap_q == '0)) begin
          state_d    = ST_ISSUE;
          data_wr_d  = 1'b1;
          data_out_d = sel_data;
          ack_d      = sel_onehot;
          grant_d    = pick_winner;
          rr_ptr_d   = pick_winner;
          gap_d      = GAP_W'(MIN_GAP - 1);
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!write_free) state_d = ST_WAIT_FREE;
      ST_WAIT_FREE: if (write_free)  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
`ifdef LETTER_ARB_WDOG_EN
    // Counter restarts on every state change, so it measures time spent in one wait state.
    if (state_d != state_q) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_FREE) begin
      if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        state_d    = ST_IDLE;
        wdog_err_d = 1'b1;
        gap_d      = GAP_W'(MIN_GAP - 1);
        wdog_cnt_d = '0;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= REQ_IDW'(NUM_REQ - 1);
      gap_q      <= '0;
      ack_q      <= '0;
      data_out_q <= '0;
      data_wr_q  <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      word_cnt_q <= '0;
`ifdef LETTER_ARB_WDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      data_out_q <= data_out_d;
      data_wr_q  <= data_wr_d;
      grant_q    <= grant_d;
      busy_q     <= (state_d != ST_IDLE);
      word_cnt_q <= word_cnt_d;
`ifdef LETTER_ARB_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign data_out = data_out_q;
  assign data_wr  = data_wr_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign word_cnt = word_cnt_q;
`ifdef LETTER_ARB_WDOG_EN
  assign wdog_err = wdog_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_letter_div_arb.sv
// Directed bench for letter_div_arb with a behavioural letter_div write_free model.
`timescale 1ns/1ps
module tb_letter_div_arb;

  localparam int MIN_GAP = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [127:0]  req_data;
  logic [3:0]    ack;
  logic          write_free;
  logic [31:0]   data_out;
  logic          data_wr;
  logic [1:0]    grant_id;
  logic          busy;
  logic [15:0]   word_cnt;
`ifdef LETTER_ARB_WDOG_EN
  logic          wdog_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_dw = -1;
  int tmr    = 0;
  bit model_en = 1'b1;

  localparam logic [31:0] P0 = 32'h6C6C6548;
  localparam logic [31:0] P1 = 32'h6F57206F;
  localparam logic [31:0] P2 = 32'h21646C72;
  localparam logic [31:0] P3 = 32'h0A0D2121;

  letter_div_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .write_free (write_free),
    .data_out   (data_out),
    .data_wr    (data_wr),
    .grant_id   (grant_id),
    .busy       (busy),
`ifdef LETTER_ARB_WDOG_EN
    .wdog_err   (wdog_err),
`endif
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // letter_div write_free: drops 2 cycles after data_wr, recovers 4 cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      tmr = 0;
    end else if (model_en) begin
      if (tmr == 0) begin
        if (data_wr) tmr = 1;
      end else begin
        tmr++;
        if (tmr == 3) write_free = 1'b0;
        if (tmr == 7) begin
          write_free = 1'b1;
          tmr = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      last_dw = -1;
    end else if (data_wr) begin
      if (last_dw >= 0) chk("dw_gap_ok", 64'((cyc - last_dw) >= MIN_GAP), 64'd1);
      last_dw = cyc;
    end
  end

  task automatic wait_dw(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (data_wr) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for data_wr", name);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  gid;
    logic [3:0]  ack;
    logic [31:0] data;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{4'b1111, 2'd1, 4'b0010, P1, 16'd2};
    vecs[1]  = '{4'b1111, 2'd2, 4'b0100, P2, 16'd3};
    vecs[2]  = '{4'b1111, 2'd3, 4'b1000, P3, 16'd4};
    vecs[3]  = '{4'b1111, 2'd0, 4'b0001, P0, 16'd5};
    vecs[4]  = '{4'b1111, 2'd1, 4'b0010, P1, 16'd6};
    vecs[5]  = '{4'b1111, 2'd2, 4'b0100, P2, 16'd7};
    vecs[6]  = '{4'b1111, 2'd3, 4'b1000, P3, 16'd8};
    vecs[7]  = '{4'b1111, 2'd0, 4'b0001, P0, 16'd9};
    vecs[8]  = '{4'b1010, 2'd1, 4'b0010, P1, 16'd10};
    vecs[9]  = '{4'b1010, 2'd3, 4'b1000, P3, 16'd11};
    vecs[10] = '{4'b0110, 2'd1, 4'b0010, P1, 16'd12};
    vecs[11] = '{4'b0100, 2'd2, 4'b0100, P2, 16'd13};
    vecs[12] = '{4'b0100, 2'd2, 4'b0100, P2, 16'd14};
    vecs[13] = '{4'b1001, 2'd3, 4'b1000, P3, 16'd15};
    vecs[14] = '{4'b1001, 2'd0, 4'b0001, P0, 16'd16};
    vecs[15] = '{4'b0001, 2'd0, 4'b0001, P0, 16'd17};
    vecs[16] = '{4'b0010, 2'd1, 4'b0010, P1, 16'd18};

    rst        = 1'b0;
    req        = 4'b0000;
    req_data   = {P3, P2, P1, P0};
    write_free = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_data_wr", 64'(data_wr), 64'h0);
    chk("rst_data_out", 64'(data_out), 64'h0);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_word_cnt", 64'(word_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single request: grant visible one cycle after it is sampled.
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    chk("single_data_wr", 64'(data_wr), 64'h1);
    chk("single_data_out", 64'(data_out), 64'(P0));
    chk("single_ack", 64'(ack), 64'h1);
    chk("single_word_cnt", 64'(word_cnt), 64'd1);
    chk("single_busy", 64'(busy), 64'h1);
    chk("single_grant", 64'(grant_id), 64'h0);
    @(negedge clk);
    chk("single_dw_pulse", 64'(data_wr), 64'h0);
    chk("single_ack_pulse", 64'(ack), 64'h0);

    for (int v = 0; v < 17; v++) begin
      req = vecs[v].req;
      wait_dw("vec_wait");
      chk("vec_grant", 64'(grant_id), 64'(vecs[v].gid));
      chk("vec_ack", 64'(ack), 64'(vecs[v].ack));
      chk("vec_data", 64'(data_out), 64'(vecs[v].data));
      chk("vec_cnt", 64'(word_cnt), 64'(vecs[v].cnt));
    end
    req = 4'b0000;
    @(negedge clk);
    chk("hold_data_out", 64'(data_out), 64'(P1));

    // Backpressure: write_free low in IDLE blocks the grant.
    repeat (12) @(negedge clk);
    model_en   = 1'b0;
    write_free = 1'b0;
    req        = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("bp_no_dw", 64'(data_wr), 64'h0);
      chk("bp_idle", 64'(busy), 64'h0);
    end
    write_free = 1'b1;
    model_en   = 1'b1;
    @(negedge clk);
    chk("bp_dw", 64'(data_wr), 64'h1);
    chk("bp_grant", 64'(grant_id), 64'd2);
    chk("bp_cnt", 64'(word_cnt), 64'd19);
    req = 4'b0000;

    // Abort in WAIT_FREE: async reset clears outputs immediately.
    repeat (12) @(negedge clk);
    req = 4'b0010;
    wait_dw("abort_wait");
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'h1);
    chk("abort_wf_low", 64'(write_free), 64'h0);
    rst        = 1'b0;
    write_free = 1'b1;
    #1;
    chk("abort_ack", 64'(ack), 64'h0);
    chk("abort_data_wr", 64'(data_wr), 64'h0);
    chk("abort_data_out", 64'(data_out), 64'h0);
    chk("abort_grant", 64'(grant_id), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_cnt", 64'(word_cnt), 64'h0);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_dw", 64'(data_wr), 64'h1);
    chk("post_abort_grant", 64'(grant_id), 64'h0);
    chk("post_abort_cnt", 64'(word_cnt), 64'd1);
    req = 4'b0000;

    // Word counter wrap.
    repeat (12) @(negedge clk);
    force dut.word_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    @(negedge clk);
    chk("wrap_preload", 64'(word_cnt), 64'hFFFF);
    req = 4'b0001;
    wait_dw("wrap_wait");
    chk("wrap_cnt", 64'(word_cnt), 64'h0);
    chk("wrap_grant", 64'(grant_id), 64'h0);
    req = 4'b0000;

`ifdef LETTER_ARB_WDOG_EN
    begin
      int k;
      repeat (12) @(negedge clk);
      model_en   = 1'b0;
      write_free = 1'b1;
      req        = 4'b0001;
      wait_dw("wdog_wait");
      req = 4'b0000;
      for (k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (wdog_err) break;
      end
      chk("wdog_delay", 64'(k), 64'd65);
      chk("wdog_busy", 64'(busy), 64'h0);
      req = 4'b0010;
      for (k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (data_wr) break;
      end
      chk("wdog_regrant_delay", 64'(k), 64'd8);
      chk("wdog_regrant_id", 64'(grant_id), 64'd1);
      req = 4'b0000;
    end
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
